// File: rtl/seg7_scan_driver.sv
// 8-digit multiplexed 7-segment driver with frame-aligned double buffering.
// Optional macro BLANK_LEADING_ZEROS_EN blanks digits above the most significant non-zero nibble.
module seg7_scan_driver (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [2:0]  count,
  input  logic [31:0] value_in,
  input  logic [7:0]  dp_in,
  input  logic        load,
  output logic        pending,
  output logic        frame_done,
  output logic [7:0]  anodes,
  output logic [6:0]  segments,
  output logic        dp
);

  // load is a single-cycle strobe with no ready: it is accepted in every cycle it is high.

  logic [31:0] shadow_val;
  logic [7:0]  shadow_dp;
  logic [31:0] disp_val;
  logic [7:0]  disp_dp;
  logic [7:0]  disp_blank;
  logic [2:0]  count_q;

  logic        boundary;
  logic        update_disp;
  logic [31:0] next_val;
  logic [7:0]  next_dp;
  logic [3:0]  cur_nibble;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

`ifdef BLANK_LEADING_ZEROS_EN
  // Digit k is blank when it and every digit above it are zero; digit 0 always shows.
  function automatic logic [7:0] blank_mask(input logic [31:0] v);
    logic [7:0] m;
    logic       seen;
    m    = 8'h00;
    seen = 1'b0;
    for (int k = 7; k >= 1; k--) begin
      seen = seen | (v[4*k +: 4] != 4'h0);
      m[k] = ~seen;
    end
    return m;
  endfunction
`endif

  always_comb begin
    boundary    = (count_q == 3'b111) && (count == 3'b000);
    update_disp = boundary && (load || pending);
    next_val    = load ? value_in : shadow_val;
    next_dp     = load ? dp_in : shadow_dp;
    cur_nibble  = disp_val[{count, 2'b00} +: 4];
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      shadow_val <= 32'h0;
      shadow_dp  <= 8'h00;
      disp_val   <= 32'h0;
      disp_dp    <= 8'h00;
      disp_blank <= 8'h00;
      pending    <= 1'b0;
      count_q    <= 3'b000;
      frame_done <= 1'b0;
    end else begin
      count_q    <= count;
      frame_done <= boundary;
      if (boundary) begin
        pending <= 1'b0;
      end else if (load) begin
        shadow_val <= value_in;
        shadow_dp  <= dp_in;
        pending    <= 1'b1;
      end
      if (update_disp) begin
        disp_val <= next_val;
        disp_dp  <= next_dp;
`ifdef BLANK_LEADING_ZEROS_EN
        disp_blank <= blank_mask(next_val);
`else
        disp_blank <= 8'h00;
`endif
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      anodes   <= 8'hFF;
      segments <= 7'h7F;
      dp       <= 1'b1;
    end else begin
      anodes   <= ~(8'b1 << count);
      segments <= disp_blank[count] ? 7'h7F : hex7(cur_nibble);
      dp       <= ~disp_dp[count];
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed frames plus randomized scan/load traffic
// against a value-level model of the display buffering.
module tb_seg7_scan_driver;

  logic        clk_in = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  count = 3'b000;
  logic [31:0] value_in = 32'h0;
  logic [7:0]  dp_in = 8'h00;
  logic        load = 1'b0;
  logic        pending;
  logic        frame_done;
  logic [7:0]  anodes;
  logic [6:0]  segments;
  logic        dp;

  int vectors = 0;
  int errors = 0;

  logic [6:0]  hex_tbl [16];
  logic [31:0] m_disp, m_shadow;
  logic [7:0]  m_dpm, m_shdp;
  logic        m_pend;
  logic [2:0]  m_cq;

  seg7_scan_driver dut (
    .clk_in(clk_in), .reset(reset), .count(count), .value_in(value_in),
    .dp_in(dp_in), .load(load), .pending(pending), .frame_done(frame_done),
    .anodes(anodes), .segments(segments), .dp(dp)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_disp = 32'h0; m_shadow = 32'h0; m_dpm = 8'h00; m_shdp = 8'h00;
    m_pend = 1'b0; m_cq = 3'b000;
  endtask

  // Called just after an active edge; applies inputs for one cycle and checks the result.
  task automatic step(input logic [2:0] c, input logic ld, input logic [31:0] v, input logic [7:0] d);
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_fd, blank;
    logic [3:0] nib;
    count = c; load = ld; value_in = v; dp_in = d;
    e_an = ~(8'b1 << c);
    nib  = 4'((m_disp >> (4 * c)) & 32'hF);
`ifdef BLANK_LEADING_ZEROS_EN
    blank = (c != 3'd0) && ((m_disp >> (4 * c)) == 32'h0);
`else
    blank = 1'b0;
`endif
    e_seg = blank ? 7'h7F : hex_tbl[nib];
    e_dp  = ~m_dpm[c];
    e_fd  = (m_cq == 3'd7) && (c == 3'd0);
    if (e_fd) begin
      if (ld) begin m_disp = v; m_dpm = d; end
      else if (m_pend) begin m_disp = m_shadow; m_dpm = m_shdp; end
      m_pend = 1'b0;
    end else if (ld) begin
      m_shadow = v; m_shdp = d; m_pend = 1'b1;
    end
    m_cq = c;
    @(posedge clk_in); #1;
    chk("anodes", 32'(anodes), 32'(e_an));
    chk("segments", 32'(segments), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("pending", 32'(pending), 32'(m_pend));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_anodes", 32'(anodes), 32'hFF);
    chk("rst_segments", 32'(segments), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
  endtask

  // Scans digits from..7 then wraps to 0; an optional load lands on digit ld_at.
  task automatic scan_frame(input int ld_at, input logic [31:0] v, input logic [7:0] d);
    for (int c = 1; c < 8; c++) step(3'(c), (c == ld_at), v, d);
    step(3'd0, (ld_at == 0), v, d);
  endtask

  initial begin
    logic [2:0] c;
    hex_tbl[0] = 7'b1000000; hex_tbl[1] = 7'b1111001; hex_tbl[2] = 7'b0100100; hex_tbl[3] = 7'b0110000;
    hex_tbl[4] = 7'b0011001; hex_tbl[5] = 7'b0010010; hex_tbl[6] = 7'b0000010; hex_tbl[7] = 7'b1111000;
    hex_tbl[8] = 7'b0000000; hex_tbl[9] = 7'b0010000; hex_tbl[10] = 7'b0001000; hex_tbl[11] = 7'b0000011;
    hex_tbl[12] = 7'b1000110; hex_tbl[13] = 7'b0100001; hex_tbl[14] = 7'b0000110; hex_tbl[15] = 7'b0001110;
    model_reset();

    // Reset state, then first decode with count held at 0.
    repeat (2) @(posedge clk_in);
    #1;
    chk_reset_outputs();
    reset = 1'b1;
    step(3'd0, 1'b0, 32'h0, 8'h00);
    chk("first_segments", 32'(segments), 32'h40);
    chk("first_anodes", 32'(anodes), 32'hFE);
    step(3'd0, 1'b0, 32'h0, 8'h00);

    // Load mid-frame, display switches only at the wrap.
    scan_frame(2, 32'h1234ABCD, 8'h05);
    scan_frame(-1, 32'h0, 8'h00);
    scan_frame(-1, 32'h0, 8'h00);

    // Two loads before one wrap: last wins.
    for (int c2 = 1; c2 < 8; c2++)
      step(3'(c2), (c2 == 2 || c2 == 5), (c2 == 2) ? 32'h11111111 : 32'h22222222, 8'h00);
    step(3'd0, 1'b0, 32'h0, 8'h00);
    scan_frame(-1, 32'h0, 8'h00);

    // Non-boundary transitions 7->3, 3->0, 0->0 while pending.
    step(3'd7, 1'b1, 32'h99999999, 8'hF0);
    step(3'd3, 1'b0, 32'h0, 8'h00);
    step(3'd0, 1'b0, 32'h0, 8'h00);
    step(3'd0, 1'b0, 32'h0, 8'h00);

    // Load on the exact boundary cycle bypasses and discards the shadow.
    for (int c2 = 1; c2 < 8; c2++) step(3'(c2), 1'b0, 32'h0, 8'h00);
    step(3'd0, 1'b1, 32'hFFFFFFFF, 8'hAA);
    scan_frame(-1, 32'h0, 8'h00);

    // Leading-zero case (blanked only when the macro is defined).
    scan_frame(0, 32'h000000A0, 8'h80);
    scan_frame(-1, 32'h0, 8'h00);

    // Asynchronous reset while a value is pending.
    step(3'd3, 1'b1, 32'h87654321, 8'h3C);
    #2 reset = 1'b0;
    #1 chk_reset_outputs();
    @(posedge clk_in); #1;
    reset = 1'b1;
    model_reset();
    scan_frame(-1, 32'h0, 8'h00);
    step(3'd0, 1'b0, 32'h0, 8'h00);
    scan_frame(-1, 32'h0, 8'h00);

    // Randomized scan and load traffic.
    c = 3'd0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 7) c = c + 3'd1;
      else c = 3'($urandom_range(0, 7));
      step(c, ($urandom_range(0, 4) == 0), $urandom, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
